// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared TAP state encoding and instruction codes for the multi-channel DAP
package jtag_pkg;

    typedef enum logic [3:0] {
        ST_TLR      = 4'h0,
        ST_RTI      = 4'h1,
        ST_SEL_DR   = 4'h2,
        ST_CAP_DR   = 4'h3,
        ST_SHIFT_DR = 4'h4,
        ST_EXIT1_DR = 4'h5,
        ST_PAUSE_DR = 4'h6,
        ST_EXIT2_DR = 4'h7,
        ST_UPD_DR   = 4'h8,
        ST_SEL_IR   = 4'h9,
        ST_CAP_IR   = 4'hA,
        ST_SHIFT_IR = 4'hB,
        ST_EXIT1_IR = 4'hC,
        ST_PAUSE_IR = 4'hD,
        ST_EXIT2_IR = 4'hE,
        ST_UPD_IR   = 4'hF
    } tap_state_e;

    localparam int IR_IDCODE  = 1;
    localparam int IR_CH_BASE = 2;

    function automatic int IR_BYPASS(input int ir_len);
        return (1 << ir_len) - 1;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - IEEE 1149.1 TAP state machine with decoded capture/shift/update strobes
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output tap_state_e state,
    output logic       tlr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr
);

    tap_state_e state_next;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) state <= ST_TLR;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_TLR:      state_next = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      state_next = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_next = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_next = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_next = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_next = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_next = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_next = tms ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_next = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_next = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_next = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_next = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_next = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_next = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_next = tms ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_next = tms ? ST_SEL_DR   : ST_RTI;
            default:     state_next = ST_TLR;
        endcase
    end

    assign tlr        = (state == ST_TLR);
    assign capture_ir = (state == ST_CAP_IR);
    assign shift_ir   = (state == ST_SHIFT_IR);
    assign update_ir  = (state == ST_UPD_IR);
    assign capture_dr = (state == ST_CAP_DR);
    assign shift_dr   = (state == ST_SHIFT_DR);
    assign update_dr  = (state == ST_UPD_DR);

endmodule

// File: rtl/jtag_multi_dap.sv
// rtl/jtag_multi_dap.sv - JTAG DAP with IDCODE, BYPASS and NUM_CH user DR channels in the tck domain
module jtag_multi_dap
    import jtag_pkg::*;
#(
    parameter int          IR_LEN     = 4,
    parameter int          NUM_CH     = 2,
    parameter int          DR_LEN     = 32,
    parameter logic [31:0] IDCODE_VAL = 32'h1DC0_0001
) (
    input  logic                       tck,
    input  logic                       trst,
    input  logic                       tms,
    input  logic                       tdi,
    output logic                       tdo,
    output logic                       tdo_en,
    input  logic [NUM_CH*DR_LEN-1:0]   ch_capture_data,
    output logic [NUM_CH-1:0]          ch_capture_strobe,
    output logic [NUM_CH*DR_LEN-1:0]   ch_update_data,
    output logic [NUM_CH-1:0]          ch_update_valid
);

    localparam int W    = (DR_LEN > 32) ? DR_LEN : 32;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    tap_state_e state;
    logic       tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

    jtag_tap_fsm u_tap_fsm (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .state      (state),
        .tlr        (tlr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr)
    );

    logic [IR_LEN-1:0] ir_sr, ir_active;
    logic [W-1:0]      dr_sr, dr_shifted, dr_capture;
    logic              sel_idcode, sel_ch;
    logic [CH_W-1:0]   ch_idx;

    // Anything that is neither IDCODE nor a channel falls through to the 1-bit bypass path
    always_comb begin
        sel_idcode = (ir_active == IR_LEN'(IR_IDCODE));
        sel_ch     = 1'b0;
        ch_idx     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ir_active == IR_LEN'(IR_CH_BASE + k)) begin
                sel_ch = 1'b1;
                ch_idx = CH_W'(k);
            end
        end
    end

    always_comb begin
        dr_capture = '0;
        if (sel_ch)          dr_capture[DR_LEN-1:0] = ch_capture_data[int'(ch_idx)*DR_LEN +: DR_LEN];
        else if (sel_idcode) dr_capture[31:0]       = IDCODE_VAL;
        dr_shifted = dr_sr >> 1;
        if (sel_ch)          dr_shifted[DR_LEN-1] = tdi;
        else if (sel_idcode) dr_shifted[31]       = tdi;
        else                 dr_shifted[0]        = tdi;
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr             <= '0;
            ir_active         <= IR_LEN'(IR_IDCODE);
            dr_sr             <= '0;
            ch_capture_strobe <= '0;
            ch_update_valid   <= '0;
            ch_update_data    <= '0;
        end else begin
            ch_capture_strobe <= '0;
            ch_update_valid   <= '0;

            if (tlr)            ir_active <= IR_LEN'(IR_IDCODE);
            else if (update_ir) ir_active <= ir_sr;

            if (capture_ir)    ir_sr <= IR_LEN'(1);
            else if (shift_ir) ir_sr <= {tdi, ir_sr[IR_LEN-1:1]};

            if (capture_dr) begin
                dr_sr <= dr_capture;
                if (sel_ch) ch_capture_strobe <= NUM_CH'(1) << ch_idx;
            end else if (shift_dr) begin
                dr_sr <= dr_shifted;
            end

            if (update_dr && sel_ch) begin
                ch_update_data[int'(ch_idx)*DR_LEN +: DR_LEN] <= dr_sr[DR_LEN-1:0];
                ch_update_valid <= NUM_CH'(1) << ch_idx;
            end
        end
    end

    // tdo launches on the falling edge so the host samples a settled bit on the next rising edge
    always_ff @(negedge tck or posedge trst) begin
        if (trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= (state == ST_SHIFT_IR) || (state == ST_SHIFT_DR);
            if (state == ST_SHIFT_IR)      tdo <= ir_sr[0];
            else if (state == ST_SHIFT_DR) tdo <= dr_sr[0];
        end
    end

endmodule

// File: tb/tb_jtag_multi_dap.sv
// tb/tb_jtag_multi_dap.sv - self-checking bench for jtag_multi_dap against a scan-level reference model
module tb_jtag_multi_dap;

    localparam int          IR_LEN     = 4;
    localparam int          NUM_CH     = 2;
    localparam int          DR_LEN     = 32;
    localparam logic [31:0] IDCODE_VAL = 32'h1DC0_0001;

    logic                     tck  = 1'b0;
    logic                     trst = 1'b1;
    logic                     tms  = 1'b1;
    logic                     tdi  = 1'b0;
    logic                     tdo, tdo_en;
    logic [NUM_CH*DR_LEN-1:0] ch_capture_data = '0;
    logic [NUM_CH-1:0]        ch_capture_strobe, ch_update_valid;
    logic [NUM_CH*DR_LEN-1:0] ch_update_data;

    int checks = 0;
    int errors = 0;

    int               upd_cnt[NUM_CH];
    int               cap_cnt[NUM_CH];
    int               exp_upd_cnt[NUM_CH];
    int               exp_cap_cnt[NUM_CH];
    logic [DR_LEN-1:0] model_upd[NUM_CH];
    int               model_ir;

    jtag_multi_dap #(
        .IR_LEN     (IR_LEN),
        .NUM_CH     (NUM_CH),
        .DR_LEN     (DR_LEN),
        .IDCODE_VAL (IDCODE_VAL)
    ) dut (
        .tck               (tck),
        .trst              (trst),
        .tms               (tms),
        .tdi               (tdi),
        .tdo               (tdo),
        .tdo_en            (tdo_en),
        .ch_capture_data   (ch_capture_data),
        .ch_capture_strobe (ch_capture_strobe),
        .ch_update_data    (ch_update_data),
        .ch_update_valid   (ch_update_valid)
    );

    always #5 tck = ~tck;

    always @(negedge tck) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_update_valid[k] === 1'b1)   upd_cnt[k]++;
            if (ch_capture_strobe[k] === 1'b1) cap_cnt[k]++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    function automatic int exp_len(input int ir);
        if (ir == 1) return 32;
        if (ir >= 2 && ir < 2 + NUM_CH) return DR_LEN;
        return 1;
    endfunction

    function automatic logic [63:0] exp_cap(input int ir);
        logic [63:0] v;
        v = '0;
        if (ir == 1) v[31:0] = IDCODE_VAL;
        else if (ir >= 2 && ir < 2 + NUM_CH) v[DR_LEN-1:0] = ch_capture_data[(ir-2)*DR_LEN +: DR_LEN];
        return v;
    endfunction

    // Serial stream seen by the register: L captured bits followed by every tdi bit
    function automatic logic [127:0] scan_stream(input logic [63:0] cap, input logic [63:0] din, input int len);
        logic [127:0] mask;
        mask = (128'd1 << len) - 128'd1;
        return ({64'd0, din} << len) | ({64'd0, cap} & mask);
    endfunction

    task automatic step(input logic m, input logic d, output logic o, output logic e);
        @(negedge tck);
        #1;
        o   = tdo;
        e   = tdo_en;
        tms = m;
        tdi = d;
    endtask

    task automatic ir_scan(input logic [IR_LEN-1:0] v, output logic [IR_LEN-1:0] dout);
        logic o, e;
        step(1'b1, 1'b0, o, e);
        step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        for (int i = 0; i < IR_LEN; i++) begin
            step(i == IR_LEN - 1, v[i], o, e);
            dout[i] = o;
        end
        step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        model_ir = int'(v);
    endtask

    task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout, output int en_cnt);
        logic o, e;
        dout   = '0;
        en_cnt = 0;
        step(1'b1, 1'b0, o, e); en_cnt += int'(e);
        step(1'b0, 1'b0, o, e); en_cnt += int'(e);
        step(1'b0, 1'b0, o, e); en_cnt += int'(e);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], o, e);
            dout[i] = o;
            en_cnt += int'(e);
        end
        step(1'b1, 1'b0, o, e); en_cnt += int'(e);
        step(1'b0, 1'b0, o, e); en_cnt += int'(e);
        step(1'b0, 1'b0, o, e); en_cnt += int'(e);
    endtask

    // Predicts a completed DR scan from the current model IR and advances the channel model
    task automatic model_dr(input int n, input logic [63:0] din, output logic [63:0] exp_out);
        int           len;
        logic [127:0] s, mask;
        len     = exp_len(model_ir);
        s       = scan_stream(exp_cap(model_ir), din, len);
        mask    = (128'd1 << n) - 128'd1;
        exp_out = 64'(s & mask);
        if (model_ir >= 2 && model_ir < 2 + NUM_CH) begin
            model_upd[model_ir-2] = DR_LEN'(s >> n);
            exp_upd_cnt[model_ir-2]++;
            exp_cap_cnt[model_ir-2]++;
        end
    endtask

    task automatic assert_trst();
        @(negedge tck);
        #2;
        trst = 1'b1;
        tms  = 1'b1;
        #1;
    endtask

    task automatic release_trst();
        logic o, e;
        @(negedge tck);
        #1;
        trst     = 1'b0;
        model_ir = 1;
        for (int k = 0; k < NUM_CH; k++) model_upd[k] = '0;
        step(1'b0, 1'b0, o, e);
    endtask

    task automatic test_reset();
        logic [63:0] dout, exp_out, din;
        int          en_cnt;
        assert_trst();
        checks++;
        if (tdo !== 1'b0 || tdo_en !== 1'b0) begin
            errors++; $display("FAIL reset_tdo: tdo=%b tdo_en=%b required 0 0", tdo, tdo_en);
        end
        checks++;
        if (ch_capture_strobe !== '0 || ch_update_valid !== '0) begin
            errors++; $display("FAIL reset_strobes: cap=%b upd=%b required 0 0", ch_capture_strobe, ch_update_valid);
        end
        checks++;
        if (ch_update_data !== '0) begin
            errors++; $display("FAIL reset_update_data: got %h required 0", ch_update_data);
        end
        release_trst();
        din = {$urandom, $urandom};
        model_dr(32, din, exp_out);
        dr_scan(32, din, dout, en_cnt);
        checks++;
        if (dout[31:0] !== IDCODE_VAL || dout[31:0] !== exp_out[31:0]) begin
            errors++; $display("FAIL idcode_read: got %h required %h", dout[31:0], IDCODE_VAL);
        end
        checks++;
        if (en_cnt !== 32) begin
            errors++; $display("FAIL idcode_tdo_en_cycles: got %0d required 32", en_cnt);
        end
    endtask

    task automatic test_ir_capture();
        logic [IR_LEN-1:0] ir_out;
        logic [63:0]       dout, exp_out;
        int                en_cnt;
        ir_scan('1, ir_out);
        checks++;
        if (ir_out !== IR_LEN'(1)) begin
            errors++; $display("FAIL ir_capture: got %b required %b", ir_out, IR_LEN'(1));
        end
        model_dr(4, 64'b1011, exp_out);
        dr_scan(4, 64'b1011, dout, en_cnt);
        checks++;
        if (dout[3:0] !== 4'b0110 || exp_out[3:0] !== 4'b0110) begin
            errors++; $display("FAIL bypass_delay: got %b required 0110", dout[3:0]);
        end
    endtask

    task automatic test_channel_write();
        logic [IR_LEN-1:0] ir_out;
        logic [63:0]       dout, exp_out;
        int                en_cnt, u0, u1;
        ir_scan(IR_LEN'(2), ir_out);
        u0 = upd_cnt[0];
        u1 = upd_cnt[1];
        model_dr(32, 64'hDEAD_BEEF, exp_out);
        dr_scan(32, 64'hDEAD_BEEF, dout, en_cnt);
        checks++;
        if (ch_update_data[31:0] !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL ch0_write: got %h required deadbeef", ch_update_data[31:0]);
        end
        checks++;
        if (ch_update_data[63:32] !== model_upd[1]) begin
            errors++; $display("FAIL ch1_untouched: got %h required %h", ch_update_data[63:32], model_upd[1]);
        end
        checks++;
        if (upd_cnt[0] - u0 !== 1 || upd_cnt[1] - u1 !== 0) begin
            errors++; $display("FAIL ch_write_valid_pulses: got %0d/%0d required 1/0", upd_cnt[0] - u0, upd_cnt[1] - u1);
        end
    endtask

    task automatic test_channel_read();
        logic [IR_LEN-1:0] ir_out;
        logic [63:0]       dout, exp_out, din;
        int                en_cnt, c0, c1;
        ch_capture_data[63:32] = 32'hA5A5_0F0F;
        ch_capture_data[31:0]  = $urandom;
        ir_scan(IR_LEN'(3), ir_out);
        c0  = cap_cnt[0];
        c1  = cap_cnt[1];
        din = {32'd0, $urandom};
        model_dr(32, din, exp_out);
        dr_scan(32, din, dout, en_cnt);
        checks++;
        if (dout[31:0] !== 32'hA5A5_0F0F) begin
            errors++; $display("FAIL ch1_read: got %h required a5a50f0f", dout[31:0]);
        end
        checks++;
        if (cap_cnt[0] - c0 !== 0 || cap_cnt[1] - c1 !== 1) begin
            errors++; $display("FAIL ch1_capture_strobe: got %0d/%0d required 0/1", cap_cnt[0] - c0, cap_cnt[1] - c1);
        end
        checks++;
        if (ch_update_data !== {model_upd[1], model_upd[0]}) begin
            errors++; $display("FAIL ch1_read_update: got %h required %h", ch_update_data, {model_upd[1], model_upd[0]});
        end
    endtask

    task automatic test_abort_and_trst();
        logic [IR_LEN-1:0] ir_out;
        logic [63:0]       dout, exp_out, din, cap;
        logic              o, e;
        int                en_pause, u0, u1, en_cnt;
        ch_capture_data[31:0] = $urandom;
        ir_scan(IR_LEN'(2), ir_out);
        cap  = exp_cap(2);
        din  = {$urandom, $urandom};
        dout = '0;
        u0   = upd_cnt[0];
        u1   = upd_cnt[1];
        step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        for (int i = 0; i < 16; i++) begin
            step(i == 15, din[i], o, e);
            dout[i] = o;
        end
        en_pause = 0;
        step(1'b0, 1'b0, o, e); en_pause += int'(e);
        step(1'b0, 1'b0, o, e); en_pause += int'(e);
        step(1'b0, 1'b0, o, e); en_pause += int'(e);
        step(1'b1, 1'b0, o, e); en_pause += int'(e);
        step(1'b0, 1'b0, o, e); en_pause += int'(e);
        for (int i = 16; i < 20; i++) begin
            step(1'b0, din[i], o, e);
            dout[i] = o;
        end
        checks++;
        if (dout[19:0] !== cap[19:0]) begin
            errors++; $display("FAIL pause_preserves: got %h required %h", dout[19:0], cap[19:0]);
        end
        checks++;
        if (en_pause !== 0) begin
            errors++; $display("FAIL pause_tdo_en: got %0d cycles required 0", en_pause);
        end
        #1;
        trst = 1'b1;
        #1;
        checks++;
        if (tdo !== 1'b0 || tdo_en !== 1'b0 || ch_update_data !== '0) begin
            errors++; $display("FAIL trst_mid_scan: tdo=%b tdo_en=%b data=%h required 0 0 0", tdo, tdo_en, ch_update_data);
        end
        release_trst();
        exp_cap_cnt[0]++;
        checks++;
        if (upd_cnt[0] - u0 !== 0 || upd_cnt[1] - u1 !== 0 || cap_cnt[0] !== exp_cap_cnt[0]) begin
            errors++; $display("FAIL abort_no_update: upd=%0d/%0d cap0=%0d required 0/0 %0d",
                               upd_cnt[0] - u0, upd_cnt[1] - u1, cap_cnt[0], exp_cap_cnt[0]);
        end
        din = {$urandom, $urandom};
        model_dr(32, din, exp_out);
        dr_scan(32, din, dout, en_cnt);
        checks++;
        if (dout[31:0] !== exp_out[31:0]) begin
            errors++; $display("FAIL trst_ir_idcode: got %h required %h", dout[31:0], exp_out[31:0]);
        end
    endtask

    task automatic test_unused_and_tms_reset();
        logic [IR_LEN-1:0] ir_out;
        logic [63:0]       dout, exp_out, din;
        logic              o, e;
        int                en_cnt, u0, u1;
        ir_scan(IR_LEN'(0), ir_out);
        din = {56'd0, 8'($urandom)};
        model_dr(8, din, exp_out);
        dr_scan(8, din, dout, en_cnt);
        checks++;
        if (dout[7:0] !== {din[6:0], 1'b0} || dout[7:0] !== exp_out[7:0]) begin
            errors++; $display("FAIL unused_code_bypass: got %b required %b", dout[7:0], {din[6:0], 1'b0});
        end
        u0 = upd_cnt[0];
        u1 = upd_cnt[1];
        step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        step(1'b0, 1'b1, o, e);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, o, e);
        step(1'b0, 1'b0, o, e);
        model_ir = 1;
        checks++;
        if (upd_cnt[0] - u0 !== 0 || upd_cnt[1] - u1 !== 0) begin
            errors++; $display("FAIL bypass_update_side_effect: got %0d/%0d required 0/0", upd_cnt[0] - u0, upd_cnt[1] - u1);
        end
        din = {$urandom, $urandom};
        model_dr(32, din, exp_out);
        dr_scan(32, din, dout, en_cnt);
        checks++;
        if (dout[31:0] !== IDCODE_VAL) begin
            errors++; $display("FAIL tms_reset_idcode: got %h required %h", dout[31:0], IDCODE_VAL);
        end
    endtask

    task automatic test_random();
        logic [IR_LEN-1:0] ir_out, ir_val;
        logic [63:0]       dout, exp_out, din, mask;
        int                en_cnt, n;
        for (int k = 0; k < NUM_CH; k++) begin
            exp_upd_cnt[k] = upd_cnt[k];
            exp_cap_cnt[k] = cap_cnt[k];
        end
        for (int it = 0; it < 24; it++) begin
            ir_val = IR_LEN'($urandom_range(0, (1 << IR_LEN) - 1));
            if (it % 3 == 0) ir_val = IR_LEN'(2 + (it / 3) % NUM_CH);
            ir_scan(ir_val, ir_out);
            checks++;
            if (ir_out !== IR_LEN'(1)) begin
                errors++; $display("FAIL rand_ir_capture[%0d]: got %b required %b", it, ir_out, IR_LEN'(1));
            end
            ch_capture_data = {$urandom, $urandom};
            din  = {$urandom, $urandom};
            n    = $urandom_range(1, 40);
            mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
            model_dr(n, din, exp_out);
            dr_scan(n, din, dout, en_cnt);
            checks++;
            if ((dout & mask) !== exp_out || en_cnt !== n) begin
                errors++; $display("FAIL rand_dr_out[%0d] ir=%0d n=%0d: got %h en=%0d required %h en=%0d",
                                   it, ir_val, n, dout & mask, en_cnt, exp_out, n);
            end
            checks++;
            if (ch_update_data !== {model_upd[1], model_upd[0]}) begin
                errors++; $display("FAIL rand_update_data[%0d]: got %h required %h", it, ch_update_data, {model_upd[1], model_upd[0]});
            end
            checks++;
            if (upd_cnt[0] !== exp_upd_cnt[0] || upd_cnt[1] !== exp_upd_cnt[1] ||
                cap_cnt[0] !== exp_cap_cnt[0] || cap_cnt[1] !== exp_cap_cnt[1]) begin
                errors++; $display("FAIL rand_pulses[%0d]: upd %0d/%0d cap %0d/%0d required upd %0d/%0d cap %0d/%0d",
                                   it, upd_cnt[0], upd_cnt[1], cap_cnt[0], cap_cnt[1],
                                   exp_upd_cnt[0], exp_upd_cnt[1], exp_cap_cnt[0], exp_cap_cnt[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ir_capture();
        test_channel_write();
        test_channel_read();
        test_abort_and_trst();
        test_unused_and_tms_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
